// File: rtl/alg_seq_ctrl.sv
// Sequencer for multi-cycle mul/div ops: start pulse, pipeline stall, result latch/hold, abort on flush or timeout.
// Start/stall/load/abort/res_src are same-cycle combinational from state and inputs; HOLD keeps the latched result while MEM stalls.
module alg_seq_ctrl #(
   parameter int TIMEOUT = 32,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_alg_op,
   input  logic             flush,
   input  logic             mem_stall,
   input  logic             alg_done,
   input  logic             stat_clr,
   output logic             alg_start,
   output logic             alg_stall,
   output logic             load_alg_reg,
   output logic             res_src,
   output logic             alg_abort,
   output logic             timeout_err,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

   localparam logic [7:0]       CYC_LAST = 8'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [7:0]       cyc_q, cyc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             terr_q, terr_d;
   logic             start_c, stall_c, load_c, src_c, abort_c;

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      terr_d  = terr_q;
      start_c = 1'b0;
      stall_c = 1'b0;
      load_c  = 1'b0;
      src_c   = 1'b0;
      abort_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (ex_alg_op && !flush) begin
               start_c = 1'b1;
               stall_c = 1'b1;
               cyc_d   = 8'd0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            cyc_d = cyc_q + 8'd1;
            // Flush beats a coincident done; timeout only fires when nothing else ends the op.
            if (flush) begin
               abort_c = 1'b1;
               state_d = IDLE;
            end else if (alg_done) begin
               load_c  = 1'b1;
               state_d = mem_stall ? HOLD : IDLE;
            end else if (cyc_q == CYC_LAST) begin
               abort_c = 1'b1;
               terr_d  = 1'b1;
               state_d = IDLE;
            end else begin
               stall_c = 1'b1;
            end
         end
         HOLD: begin
            src_c = 1'b1;
            if (!mem_stall || flush) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stat_clr) begin
         cnt_d = '0;
      end else if (stall_c && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cyc_q   <= 8'd0;
         cnt_q   <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
      end
   end

   // Gate the combinational strobes so every output reads 0 while reset is held.
   assign alg_start    = rst_n & start_c;
   assign alg_stall    = rst_n & stall_c;
   assign load_alg_reg = rst_n & load_c;
   assign res_src      = rst_n & src_c;
   assign alg_abort    = rst_n & abort_c;
   assign timeout_err  = terr_q;
   assign stall_count  = cnt_q;

endmodule

// File: tb/tb_alg_seq_ctrl.sv
// Randomized + directed bench for alg_seq_ctrl against a transaction-level model (ordinal BUSY cycle, hold flag).
module tb_alg_seq_ctrl;
   localparam int TO   = 32;
   localparam int CW   = 6;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0, rst_n = 1'b0;
   logic ex_alg_op = 1'b0, flush = 1'b0, mem_stall = 1'b0, alg_done = 1'b0, stat_clr = 1'b0;
   logic alg_start, alg_stall, load_alg_reg, res_src, alg_abort, timeout_err;
   logic [CW-1:0] stall_count;

   alg_seq_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .ex_alg_op(ex_alg_op), .flush(flush),
      .mem_stall(mem_stall), .alg_done(alg_done), .stat_clr(stat_clr),
      .alg_start(alg_start), .alg_stall(alg_stall), .load_alg_reg(load_alg_reg),
      .res_src(res_src), .alg_abort(alg_abort), .timeout_err(timeout_err),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;
   // Model: m_busy = ordinal of the current BUSY cycle (0 = no op in flight).
   int m_busy = 0, m_cnt = 0;
   bit m_hold = 0, m_terr = 0;
   bit e_start, e_stall, e_load, e_src, e_abort;
   int t_start, t_stall, t_load, t_src, t_abort;
   int cyc_no = 0, last_start = 0, prev_start = 0, abort_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_outputs();
      e_start = 0; e_stall = 0; e_load = 0; e_src = 0; e_abort = 0;
      if (rst_n !== 1'b1) begin
      end else if (m_hold) begin
         e_src = 1;
      end else if (m_busy > 0) begin
         if (flush) e_abort = 1;
         else if (alg_done) e_load = 1;
         else if (m_busy == TO) e_abort = 1;
         else e_stall = 1;
      end else if (ex_alg_op && !flush) begin
         e_start = 1;
         e_stall = 1;
      end
   endtask

   task automatic model_advance();
      if (m_hold) begin
         if (!mem_stall || flush) m_hold = 0;
      end else if (m_busy > 0) begin
         if (flush) m_busy = 0;
         else if (alg_done) begin m_busy = 0; m_hold = mem_stall; end
         else if (m_busy == TO) begin m_busy = 0; m_terr = 1; end
         else m_busy++;
      end else if (e_start) begin
         m_busy = 1;
      end
      if (stat_clr) m_cnt = 0;
      else if (e_stall && m_cnt < CMAX) m_cnt++;
   endtask

   task automatic compare_all();
      chk("alg_start", alg_start, e_start);
      chk("alg_stall", alg_stall, e_stall);
      chk("load_alg_reg", load_alg_reg, e_load);
      chk("res_src", res_src, e_src);
      chk("alg_abort", alg_abort, e_abort);
      chk("timeout_err", timeout_err, m_terr);
      chk("stall_count", stall_count, m_cnt);
   endtask

   task automatic clear_tally();
      t_start = 0; t_stall = 0; t_load = 0; t_src = 0; t_abort = 0;
   endtask

   task automatic step(input bit op, input bit fl, input bit ms, input bit dn, input bit clr);
      @(negedge clk);
      ex_alg_op = op; flush = fl; mem_stall = ms; alg_done = dn; stat_clr = clr;
      #1;
      model_outputs();
      compare_all();
      t_start += int'(alg_start); t_stall += int'(alg_stall); t_load += int'(load_alg_reg);
      t_src += int'(res_src); t_abort += int'(alg_abort);
      if (alg_start === 1'b1) begin prev_start = last_start; last_start = cyc_no; end
      if (alg_abort === 1'b1) abort_cyc = cyc_no;
      @(posedge clk);
      model_advance();
      cyc_no++;
      #1;
   endtask

   task automatic reset_async(input bit op);
      @(negedge clk);
      #2;
      ex_alg_op = op; flush = 1'b0; mem_stall = 1'b1; alg_done = 1'b0; stat_clr = 1'b0;
      rst_n = 1'b0;
      #1;
      m_busy = 0; m_hold = 0; m_cnt = 0; m_terr = 0;
      model_outputs();
      compare_all();
      @(posedge clk);
      #1;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
      ex_alg_op = 0; flush = 0; mem_stall = 0; alg_done = 0; stat_clr = 0;
   endtask

   initial begin
      int dr;
      #1;
      model_outputs();
      compare_all();
      #20;
      @(negedge clk);
      rst_n = 1'b1;

      // done on 4th BUSY cycle, no MEM stall
      step(0, 0, 0, 0, 1);
      clear_tally();
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      chk("d1_starts", t_start, 1);
      chk("d1_stalls", t_stall, 4);
      chk("d1_loads", t_load, 1);
      chk("d1_count", stall_count, 4);

      // MEM stall for 3 cycles from done -> 3 HOLD cycles, ex_alg_op ignored there
      clear_tally();
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
      step(0, 0, 1, 1, 0);
      step(1, 0, 1, 0, 0);
      step(1, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("d2_res_src", t_src, 3);
      chk("d2_starts", t_start, 1);
      chk("d2_count", stall_count, 8);

      // flush with done on 3rd BUSY cycle
      clear_tally();
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0);
      chk("d3_abort", t_abort, 1);
      chk("d3_loads", t_load, 0);
      step(1, 0, 0, 0, 0);
      chk("d3_restart", t_start, 2);
      step(0, 1, 0, 0, 0);

      // timeout
      clear_tally();
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < TO; i++) step(0, 0, 0, 0, 0);
      chk("d4_abort_pos", abort_cyc - last_start, TO);
      chk("d4_abort_n", t_abort, 1);
      chk("d4_stalls", t_stall, TO);
      chk("d4_terr", timeout_err, 1);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
      chk("d4_terr_sticky", timeout_err, 1);

      // back-to-back ops, done after 2 BUSY cycles each
      step(0, 0, 0, 0, 1);
      clear_tally();
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      chk("d5_start_gap", last_start - prev_start, 3);
      chk("d5_starts", t_start, 2);
      chk("d5_count", stall_count, 4);
      step(0, 0, 0, 0, 1);
      chk("d5_clr", stall_count, 0);

      // reset mid-BUSY
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      reset_async(1);
      chk("d6_terr", timeout_err, 0);
      step(0, 0, 0, 0, 0);
      chk("d6_count", stall_count, 0);
      clear_tally();
      step(1, 0, 0, 0, 0);
      chk("d6_restart", t_start, 1);

      // randomized phase
      dr = 3;
      for (int i = 0; i < 4000; i++) begin
         if (i % 500 == 0) dr = (i % 1000 == 0) ? 3 : 45;
         if ($urandom_range(299) == 0) reset_async(1'($urandom_range(1)));
         step(($urandom_range(2) != 0), ($urandom_range(15) == 0), ($urandom_range(2) == 0),
              ($urandom_range(dr - 1) == 0), ($urandom_range(399) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
